// File: rtl/iir_filter_ctrl_pkg.sv
// Shared types and constants for the IIR filter sequencer: FSM states, gain
// end points, NCO width and the saturating gain-step helpers.
package iir_filter_ctrl_pkg;

  localparam int NCO_W = 32;

  localparam logic [7:0] GAIN_UNITY = 8'd255;
  localparam logic [7:0] GAIN_MUTE  = 8'd0;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT,
    ST_MUTE,
    ST_CLEAR,
    ST_UNMUTE,
    ST_DONE
  } state_e;

  function automatic logic [7:0] gain_sub(input logic [7:0] g, input logic [7:0] step);
    return (g > step) ? g - step : GAIN_MUTE;
  endfunction

  function automatic logic [7:0] gain_add(input logic [7:0] g, input logic [7:0] step);
    return ((GAIN_UNITY - g) > step) ? g + step : GAIN_UNITY;
  endfunction

endpackage

// File: rtl/iir_ce_nco.sv
// Fractional NCO producing the filter clock-enable at 2x the sample rate and
// the sample strobe on every second enable.
module iir_ce_nco
  import iir_filter_ctrl_pkg::*;
#(
  parameter int unsigned CLK_RATE    = 24576000,
  parameter int unsigned SAMPLE_RATE = 48000
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_rate,
  output logic filt_ce,
  output logic filt_sample_ce
);

  localparam logic [NCO_W-1:0] INC_BASE = NCO_W'(2 * SAMPLE_RATE);
  localparam logic [NCO_W-1:0] INC_FAST = NCO_W'(4 * SAMPLE_RATE);
  localparam logic [NCO_W-1:0] MODULUS  = NCO_W'(CLK_RATE);

  // Two enables must never land on adjacent clocks, even at the fast rate.
  if (8 * SAMPLE_RATE > CLK_RATE) begin : g_bad_rate
    $error("iir_ce_nco: 2*INC exceeds CLK_RATE");
  end

  logic [NCO_W-1:0] acc;
  logic [NCO_W-1:0] sum;
  logic             wrap;
  logic             phase;

  assign sum  = acc + (sample_rate ? INC_FAST : INC_BASE);
  assign wrap = (sum >= MODULUS);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc            <= '0;
      phase          <= 1'b0;
      filt_ce        <= 1'b0;
      filt_sample_ce <= 1'b0;
    end else begin
      acc            <= wrap ? sum - MODULUS : sum;
      filt_ce        <= wrap;
      filt_sample_ce <= wrap & phase;
      if (wrap) phase <= ~phase;
    end
  end

endmodule

// File: rtl/iir_filter_ctrl.sv
// Sequencer for the shared 2-channel IIR filter: ce generation plus the
// mute/clear/switch/unmute bank change. Ramped gain when IIR_FILTER_CTRL_RAMP_EN is defined.
module iir_filter_ctrl
  import iir_filter_ctrl_pkg::*;
#(
  parameter int unsigned CLK_RATE    = 24576000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned CLR_FRAMES  = 4,
  parameter int unsigned RAMP_STEP   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_rate,
  input  logic [1:0] cfg_sel,
  input  logic       cfg_req,
  output logic       cfg_ack,
  output logic       busy,
  output logic       filt_ce,
  output logic       filt_sample_ce,
  output logic [1:0] filt_sel,
  output logic       filt_clr,
  output logic [7:0] gain
);

  if (CLR_FRAMES == 0 || CLR_FRAMES > 255) begin : g_bad_clr
    $error("iir_filter_ctrl: CLR_FRAMES must be 1..255");
  end
  if (RAMP_STEP == 0 || RAMP_STEP > 255) begin : g_bad_step
    $error("iir_filter_ctrl: RAMP_STEP must be 1..255");
  end

  localparam logic [7:0] CLR_LAST = 8'(CLR_FRAMES - 1);

  iir_ce_nco #(
    .CLK_RATE    (CLK_RATE),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_nco (
    .clk            (clk),
    .reset          (reset),
    .sample_rate    (sample_rate),
    .filt_ce        (filt_ce),
    .filt_sample_ce (filt_sample_ce)
  );

  state_e     state, state_d;
  logic [1:0] sel_lat, sel_lat_d, filt_sel_d;
  logic [7:0] frame_cnt, frame_cnt_d;
  logic [7:0] gain_d, gain_dn, gain_up;

`ifdef IIR_FILTER_CTRL_RAMP_EN
  assign gain_dn = gain_sub(gain, 8'(RAMP_STEP));
  assign gain_up = gain_add(gain, 8'(RAMP_STEP));
`else
  assign gain_dn = GAIN_MUTE;
  assign gain_up = GAIN_UNITY;
`endif

  assign busy     = (state != ST_RUN);
  assign cfg_ack  = (state == ST_DONE);
  assign filt_clr = (state == ST_CLEAR);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    sel_lat_d   = sel_lat;
    filt_sel_d  = filt_sel;
    frame_cnt_d = frame_cnt;
    gain_d      = gain;
    case (state)
      ST_RUN: begin
        if (cfg_req && !cfg_ack) begin
          sel_lat_d = cfg_sel;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (filt_sample_ce) state_d = ST_MUTE;
      end
      ST_MUTE: begin
        if (filt_sample_ce) begin
          gain_d = gain_dn;
          // The bank swaps on the same edge that reaches silence.
          if (gain_dn == GAIN_MUTE) begin
            state_d     = ST_CLEAR;
            filt_sel_d  = sel_lat;
            frame_cnt_d = '0;
          end
        end
      end
      ST_CLEAR: begin
        if (filt_sample_ce) begin
          if (frame_cnt == CLR_LAST) state_d = ST_UNMUTE;
          else frame_cnt_d = frame_cnt + 8'd1;
        end
      end
      ST_UNMUTE: begin
        if (filt_sample_ce) begin
          gain_d = gain_up;
          if (gain_up == GAIN_UNITY) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!cfg_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      sel_lat   <= '0;
      filt_sel  <= '0;
      frame_cnt <= '0;
      gain      <= GAIN_UNITY;
    end else begin
      state     <= state_d;
      sel_lat   <= sel_lat_d;
      filt_sel  <= filt_sel_d;
      frame_cnt <= frame_cnt_d;
      gain      <= gain_d;
    end
  end

endmodule

// File: tb/tb_iir_filter_ctrl.sv
// Scoreboard bench for iir_filter_ctrl: NCO timing, rate switch, bank-change
// sequences (ramped or stepped by IIR_FILTER_CTRL_RAMP_EN) and async reset.
module tb_iir_filter_ctrl;

  localparam int CLK_RATE    = 24576000;
  localparam int SAMPLE_RATE = 48000;
  localparam int CLR_FRAMES  = 4;
  localparam int RAMP_STEP   = 16;
  localparam int INC0        = 2 * SAMPLE_RATE;
  localparam int INC1        = 4 * SAMPLE_RATE;
  localparam int P0          = CLK_RATE / INC0;
  localparam int P1          = CLK_RATE / INC1;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_rate;
  logic [1:0] cfg_sel;
  logic       cfg_req;
  logic       cfg_ack, busy, filt_ce, filt_sample_ce, filt_clr;
  logic [1:0] filt_sel;
  logic [7:0] gain;

  int n_cmp = 0;
  int n_err = 0;
  int sel_glitch = 0;
  logic [1:0] sel_prev = 2'd0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  iir_filter_ctrl #(
    .CLK_RATE    (CLK_RATE),
    .SAMPLE_RATE (SAMPLE_RATE),
    .CLR_FRAMES  (CLR_FRAMES),
    .RAMP_STEP   (RAMP_STEP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_rate    (sample_rate),
    .cfg_sel        (cfg_sel),
    .cfg_req        (cfg_req),
    .cfg_ack        (cfg_ack),
    .busy           (busy),
    .filt_ce        (filt_ce),
    .filt_sample_ce (filt_sample_ce),
    .filt_sel       (filt_sel),
    .filt_clr       (filt_clr),
    .gain           (gain)
  );

  always #5 clk = ~clk;

  // The active bank may only move while muted and clearing.
  always @(negedge clk) begin
    if (!reset && filt_sel != sel_prev && !(gain == 8'd0 && filt_clr)) sel_glitch++;
    sel_prev = filt_sel;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  task automatic sb_check(input logic [31:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] fw(input logic b, input logic a, input logic c,
                                     input logic [1:0] s, input logic [7:0] g);
    return {19'd0, b, a, c, s, g};
  endfunction

  // Expected {busy,ack,clr,sel,gain} one clk after each frame strobe of a sequence.
  function automatic int push_seq(input logic [1:0] sel, input logic [1:0] old);
    int n = 0;
    int g;
    push("f_wait", fw(1'b1, 1'b0, 1'b0, old, 8'd255)); n++;
`ifdef IIR_FILTER_CTRL_RAMP_EN
    g = 255;
    do begin
      g = (g > RAMP_STEP) ? g - RAMP_STEP : 0;
      push("f_mute", (g == 0) ? fw(1'b1, 1'b0, 1'b1, sel, 8'd0) : fw(1'b1, 1'b0, 1'b0, old, 8'(g)));
      n++;
    end while (g != 0);
`else
    g = 0;
    push("f_mute", fw(1'b1, 1'b0, 1'b1, sel, 8'(g))); n++;
`endif
    for (int j = 1; j <= CLR_FRAMES; j++) begin
      push("f_clear", fw(1'b1, 1'b0, j < CLR_FRAMES, sel, 8'd0)); n++;
    end
`ifdef IIR_FILTER_CTRL_RAMP_EN
    do begin
      g = ((255 - g) > RAMP_STEP) ? g + RAMP_STEP : 255;
      push("f_unmute", (g == 255) ? fw(1'b1, 1'b1, 1'b0, sel, 8'd255) : fw(1'b1, 1'b0, 1'b0, sel, 8'(g)));
      n++;
    end while (g != 255);
`else
    push("f_unmute", fw(1'b1, 1'b1, 1'b0, sel, 8'd255)); n++;
`endif
    return n;
  endfunction

  task automatic wait_ce(output int gap, output logic smp);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!filt_ce && gap < 1000);
    check("ce_seen", {31'd0, filt_ce}, 32'd1);
    smp = filt_sample_ce;
  endtask

  task automatic start_req(input logic [1:0] sel);
    do @(negedge clk); while (filt_sample_ce);
    cfg_sel = sel;
    cfg_req = 1'b1;
  endtask

  task automatic run_frames(input int n_frames, input int drop_at, input int resel_at);
    int   seen = 0;
    int   cyc  = 0;
    logic pend = 1'b0;
    while (seen < n_frames && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        seen++;
        sb_check(fw(busy, cfg_ack, filt_clr, filt_sel, gain));
        if (seen == drop_at) cfg_req = 1'b0;
        if (seen == resel_at) cfg_sel = 2'd3;
      end
      pend = filt_sample_ce;
    end
    check("seq_frames", seen, n_frames);
  endtask

  initial begin
    int   n_ce, n_sce, bad_gap, last, first, gap, n, cyc;
    logic smp;

    reset = 1'b1; sample_rate = 1'b0; cfg_sel = 2'd0; cfg_req = 1'b0;
    #1;
    push("rst_outputs", fw(1'b0, 1'b0, 1'b0, 2'd0, 8'd255));
    sb_check(fw(busy, cfg_ack, filt_clr, filt_sel, gain));
    push("rst_strobes", 32'd0);
    sb_check({30'd0, filt_ce, filt_sample_ce});
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1 ms at the base rate
    push("t1_ce_count", 32'd96);
    push("t1_sce_count", 32'd48);
    push("t1_first_ce", P0);
    push("t1_bad_spacing", 32'd0);
    n_ce = 0; n_sce = 0; bad_gap = 0; last = 0; first = -1;
    for (int c = 1; c <= CLK_RATE / 1000; c++) begin
      @(negedge clk);
      if (filt_sample_ce && !filt_ce) bad_gap++;
      if (filt_ce) begin
        n_ce++;
        if (filt_sample_ce) n_sce++;
        if (first < 0) first = c;
        else if (c - last != P0) bad_gap++;
        last = c;
      end
    end
    sb_check(n_ce); sb_check(n_sce); sb_check(first); sb_check(bad_gap);

    // Rate switch 100 clk after an enable
    repeat (100) @(negedge clk);
    sample_rate = 1'b1;
    push("t2_gap0", 100 + (CLK_RATE - 100 * INC0) / INC1); push("t2_smp0", 32'd0);
    push("t2_gap1", P1); push("t2_smp1", 32'd1);
    push("t2_gap2", P1); push("t2_smp2", 32'd0);
    wait_ce(gap, smp); sb_check(gap + 100); sb_check({31'd0, smp});
    wait_ce(gap, smp); sb_check(gap);       sb_check({31'd0, smp});
    wait_ce(gap, smp); sb_check(gap);       sb_check({31'd0, smp});

    // Bank change to 2; cfg_sel moves to 3 mid-sequence; cfg_req held after ack
    start_req(2'd2);
    n = push_seq(2'd2, 2'd0);
    run_frames(n, 0, 2);
    repeat (6 * P1) @(negedge clk);
    push("t5_hold", fw(1'b1, 1'b1, 1'b0, 2'd2, 8'd255));
    sb_check(fw(busy, cfg_ack, filt_clr, filt_sel, gain));
    cfg_req = 1'b0;
    push("t5_ack_same_clk", 32'd1);
    sb_check({31'd0, cfg_ack});
    @(negedge clk);
    push("t5_ack_drop", 32'd0);
    sb_check({30'd0, cfg_ack, busy});

    // Bank change to 3 with cfg_req dropped after the first frame
    start_req(2'd3);
    n = push_seq(2'd3, 2'd2);
    run_frames(n, 1, 0);
    @(negedge clk);
    push("t3b_done_exit", 32'd0);
    sb_check({30'd0, cfg_ack, busy});

    // Reset asserted during CLEAR, away from the clock edge
    start_req(2'd1);
    cyc = 0;
    while (!filt_clr && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_in_clear", {31'd0, filt_clr}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    push("t6_async_rst", fw(1'b0, 1'b0, 1'b0, 2'd0, 8'd255));
    sb_check(fw(busy, cfg_ack, filt_clr, filt_sel, gain));
    cfg_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push("t6_first_gap", P1); push("t6_first_smp", 32'd0);
    push("t6_next_gap", P1);  push("t6_next_smp", 32'd1);
    wait_ce(gap, smp); sb_check(gap); sb_check({31'd0, smp});
    wait_ce(gap, smp); sb_check(gap); sb_check({31'd0, smp});

    push("sel_only_when_muted", 32'd0);
    sb_check(sel_glitch);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
